// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t  : receive FSM states
//   ST_*        : bit positions inside the status byte
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int ST_AVAIL   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_FRAMING = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a count register.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   push, din       : write strobe and data; accepted when not full or when a
//                     pop happens in the same cycle
//   pop             : read strobe; ignored when empty
//   dout            : head entry, zero when empty
//   count           : number of stored entries (0..DEPTH)
//   full, empty     : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_s, pop_s;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;
  assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rptr_q];

  // Accept logic and next pointer/count; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    pop_s   = pop && !empty;
    push_s  = push && (!full || pop_s);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a byte FIFO and sticky status.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   rd_en      : pop strobe (data-register read)
//   clr_err    : clears the sticky overrun/framing bits
//   rd_data    : FIFO head byte, 0x00 when empty
//   status     : {5'b0, framing, overrun, data available}
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic [7:0] status
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovr_q, ovr_d, frm_q, frm_d;
  logic            byte_done_s, frame_err_s, overrun_s, fall_s, cnt_zero_s;
  logic [CNTW-1:0] fifo_count_s;
  logic            fifo_full_s, fifo_empty_s;

  // Two-flop synchroniser plus a delayed copy used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_s     = prev_q && !sync2_q;
  assign cnt_zero_s = (clk_cnt_q == {CW{1'b0}});

  // Receive FSM next-state logic; every sample point is where the countdown hits zero.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d   = START;
          clk_cnt_d = HALF_M1;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_zero_s) begin
          if (!sync2_q) begin
            state_d   = DATA;
            clk_cnt_d = FULL_M1;
          end else begin
            state_d = IDLE;  // glitch, no error
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_zero_s) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          clk_cnt_d = FULL_M1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_zero_s) begin
          state_d = IDLE;
          if (sync2_q) begin
            byte_done_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= {CW{1'b0}};
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (byte_done_s),
    .pop   (rd_en),
    .din   (shift_q),
    .dout  (rd_data),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // A completed byte is lost only if the FIFO is full and no real pop frees a slot.
  assign overrun_s = byte_done_s && fifo_full_s && !(rd_en && !fifo_empty_s);

  // Sticky error bits: a new error in the same cycle as clr_err keeps the bit set.
  always_comb begin
    ovr_d = ovr_q;
    frm_d = frm_q;
    if (overrun_s) begin
      ovr_d = 1'b1;
    end else if (clr_err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (frame_err_s) begin
      frm_d = 1'b1;
    end else if (clr_err) begin
      frm_d = 1'b0;
    end else begin
      frm_d = frm_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      frm_q <= frm_d;
    end
  end

  // Status byte assembled from flops only.
  always_comb begin
    status             = 8'h00;
    status[ST_AVAIL]   = (fifo_count_s != {CNTW{1'b0}});
    status[ST_OVERRUN] = ovr_q;
    status[ST_FRAMING] = frm_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_uart_rx_fifo;

  localparam int C   = 16;
  localparam int D   = 4;
  localparam int LAT = 3 + C / 2 + 9 * C;  // falling edge to byte visible

  logic       clk = 1'b0;
  logic       reset, rx, rd_en, clr_err;
  logic [7:0] rd_data, status;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rd_en   (rd_en),
    .clr_err (clr_err),
    .rd_data (rd_data),
    .status  (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] b;
    logic       ok;
  } ev_t;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  logic [7:0] mq[$];
  ev_t        sched[$];
  logic       m_ovr = 1'b0;
  logic       m_frm = 1'b0;

  // Reference model: frames complete LAT cycles after their start; FIFO as a queue.
  initial begin
    ev_t  ev;
    bit   got, pop, ovr_ev, frm_ev;
    logic [7:0] dummy;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        sched.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
      end else begin
        got = 1'b0; ovr_ev = 1'b0; frm_ev = 1'b0;
        pop = rd_en && (mq.size() > 0);
        if (sched.size() > 0 && sched[0].due == cyc) begin
          ev  = sched.pop_front();
          got = 1'b1;
        end
        if (pop) dummy = mq.pop_front();
        if (got) begin
          if (!ev.ok) frm_ev = 1'b1;
          else if (mq.size() < D) mq.push_back(ev.b);
          else ovr_ev = 1'b1;
        end
        if (ovr_ev) m_ovr = 1'b1; else if (clr_err) m_ovr = 1'b0;
        if (frm_ev) m_frm = 1'b1; else if (clr_err) m_frm = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic [7:0] exp_st, exp_rd;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        exp_st = {5'b00000, m_frm, m_ovr, (mq.size() != 0)};
        exp_rd = (mq.size() != 0) ? mq[0] : 8'h00;
        checks++;
        if (status !== exp_st || rd_data !== exp_rd) begin
          errors++;
          $display("FAIL model_cmp cyc=%0d status=%02h want=%02h rd_data=%02h want=%02h",
                   cyc, status, exp_st, rd_data, exp_rd);
        end
      end
    end
  end

  task automatic expect8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%02h want=%02h", name, act, exp);
    end
  endtask

  // Send one frame from the next falling clock edge. pin: check visibility timing
  // (expects empty/clean status before). pop_at/abort_at: frame-relative cycle, -1 = none.
  task automatic send(input logic [7:0] b, input logic stop, input bit pin,
                      input int pop_at, input int abort_at);
    logic [9:0] fr;
    ev_t        e;
    int         f;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    f = cyc;
    e.due = f + LAT; e.b = b; e.ok = stop;
    sched.push_back(e);
    for (int k = 0; k < 10 * C; k++) begin
      if (k != 0) @(negedge clk);
      if (k == abort_at) begin
        reset = 1'b1; rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      rx = fr[k / C];
      if (pop_at >= 0) rd_en = (k == pop_at);
      if (pin && k == LAT - 1) expect8("avail_before", status, 8'h00);
      if (pin && k == LAT) begin
        expect8("avail_at", status, 8'h01);
        expect8("data_at", rd_data, b);
      end
    end
    @(negedge clk);
    rx = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    expect8(name, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    bit done;
    reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    expect8("reset_status", status, 8'h00);
    expect8("reset_rd_data", rd_data, 8'h00);
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single byte with timing pin
    send(8'h55, 1'b1, 1'b1, -1, -1);
    expect8("t1_status", status, 8'h01);
    pop_chk("t1_data", 8'h55);
    expect8("t1_status_after", status, 8'h00);
    expect8("t1_data_after", rd_data, 8'h00);

    // 2: back-to-back bytes, in-order pops
    send(8'hA3, 1'b1, 1'b0, -1, -1);
    send(8'h00, 1'b1, 1'b0, -1, -1);
    send(8'hFF, 1'b1, 1'b0, -1, -1);
    pop_chk("t2_pop0", 8'hA3);
    pop_chk("t2_pop1", 8'h00);
    expect8("t2_avail_before_last", status, 8'h01);
    pop_chk("t2_pop2", 8'hFF);
    expect8("t2_avail_after", status, 8'h00);

    // 3: overrun on fifth byte, then clear
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, -1, -1);
    expect8("t3_status", status, 8'h03);
    expect8("t3_head", rd_data, 8'h01);
    pulse_clr();
    expect8("t3_status_clr", status, 8'h01);
    for (int i = 1; i <= 4; i++) pop_chk("t3_pop", 8'(i));
    expect8("t3_empty", status, 8'h00);

    // 4: framing error
    send(8'h42, 1'b0, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    expect8("t4_status", status, 8'h04);
    pulse_clr();
    expect8("t4_status_clr", status, 8'h00);

    // 5: short glitch
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    expect8("t5_status", status, 8'h00);

    // 6: reset mid-frame, then a clean frame
    send(8'hC3, 1'b1, 1'b0, -1, 80);
    repeat (200) @(negedge clk);
    expect8("t6_status", status, 8'h00);
    send(8'h7E, 1'b1, 1'b0, -1, -1);
    expect8("t6_status2", status, 8'h01);
    pop_chk("t6_data", 8'h7E);

    // 7: push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, 1'b0, -1, -1);
    send(8'h14, 1'b1, 1'b0, LAT - 1, -1);
    expect8("t7_status", status, 8'h01);
    for (int i = 1; i <= 4; i++) pop_chk("t7_pop", 8'h10 + 8'(i));
    expect8("t7_empty", status, 8'h00);

    // Randomized phase
    done = 1'b0;
    fork
      begin
        int r;
        for (int i = 0; i < 60; i++) begin
          r = $urandom_range(0, 19);
          if (r < 2) begin
            @(negedge clk);
            rx = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            rx = 1'b1;
            repeat (12) @(negedge clk);
          end else begin
            send(8'($urandom), (r >= 4), 1'b0, -1, -1);
          end
          repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          rd_en   = ($urandom_range(0, 199) == 0);
          clr_err = ($urandom_range(0, 299) == 0);
        end
        rd_en   = 1'b0;
        clr_err = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
